retire_trace_fifo: RTL and testbench
====================================

// Module: retire_trace_fifo
// PURPOSE
//  Downstream observer of the single-cycle MIPS datapath. Captures one retirement record per clock
//  (PC, instruction, register-file write). Buffers records in a FIFO that a host/bench drains
//  through a valid/ready port. Raises stall_req so the PC update can be frozen before records drop.
// PARAMETERS
//  DEPTH         16  FIFO entries; power of two, >= 4
//  ADDR_W         4  log2(DEPTH)
//  STALL_MARGIN   2  stall_req asserts when count >= DEPTH-STALL_MARGIN
//  CAPTURE_ALL    0  1: capture every retiring instr; 0: only reg writes to rd!=0 or mem writes
// PORTS
//  clk            in   1   rising-edge clock, shared with pc/register_file
//  rst            in   1   synchronous, active-high reset
//  in_valid       in   1   an instruction retires this cycle
//  in_pc          in   32  address of the retiring instruction (pc nextpc)
//  in_instr       in   32  instruction word
//  in_reg_write   in   1   control unit reg_write
//  in_write_reg   in   5   output of the write-register mux
//  in_write_data  in   32  output of the MemtoReg mux
//  in_mem_write   in   1   control unit mem_write
//  out_valid      out  1   head record available
//  out_ready      in   1   consumer accepts head record
//  out_seq        out  16  sequence number of head record
//  out_pc         out  32  head record PC
//  out_instr      out  32  head record instruction
//  out_wr_en      out  1   head record wrote a register (reg_write && rd!=0)
//  out_wr_reg     out  5   head record destination register
//  out_wr_data    out  32  head record write data
//  count          out  ADDR_W+1  current occupancy, 0..DEPTH
//  stall_req      out  1   registered; asserted when count >= DEPTH-STALL_MARGIN
//  overflow       out  1   sticky: at least one record was dropped
//  drop_cnt       out  8   dropped records, saturates at 255
//  clr_overflow   in   1   clears overflow and drop_cnt (next edge)
// BEHAVIOUR
//  - Reset: pointers, count, seq counter, overflow, drop_cnt, stall_req = 0. out_valid = 0.
//    FIFO contents discarded. Reset mid-stream drops all buffered records with no drain.
//  - want = in_valid && (CAPTURE_ALL || (in_reg_write && in_write_reg!=0) || in_mem_write).
//  - pop = out_valid && out_ready. push = want && (count<DEPTH || pop).
//    Full with simultaneous pop: the push is accepted and count stays at DEPTH.
//  - Record fields are latched on the push edge.
//    wr_en stored as in_reg_write && (in_write_reg!=0).
//  - First-word fall-through: out_* driven from the head entry.
//    A record pushed at edge N is visible on out_* after edge N (one-cycle latency when empty).
//  - out_* hold stable while out_valid && !out_ready.
//    When out_valid=0, out_* hold their last value (don't-care to consumer).
//  - Empty with push and no pop: no bypass; out_valid rises the cycle after the push.
//  - Sequence counter (16 bit) increments on every want, whether accepted or dropped.
//    It wraps 0xFFFF->0x0000. A gap in out_seq therefore identifies drops.
//  - Drop (want && !push): overflow<=1, drop_cnt<=min(drop_cnt+1,255).
//    clr_overflow has priority over a same-cycle drop.
//  - count updates: +1 push only, -1 pop only, unchanged for both or neither.
//    Pointers wrap modulo DEPTH.
//  - stall_req is computed from next-state count.
//    It is registered, so it asserts on the same edge at which count reaches the threshold.
// TESTING
//  1 rst, then 3 retires with reg_write=1, rd=8, out_ready=0
//    -> count=3, out_seq=0, out_pc=0x0, out_wr_reg=8.
//  2 CAPTURE_ALL=0: retire with reg_write=1, rd=0, mem_write=0 -> no push, seq unchanged.
//    Beq (reg_write=0, mem_write=0) -> no push.
//  3 Fill to 16 with out_ready=0: stall_req high once count=14.
//    17th want -> overflow=1, drop_cnt=1, next accepted record shows seq gap of 1.
//  4 Full, in_valid and out_ready both 1 for 5 cycles -> count stays 16, no drops, seqs contiguous.
//  5 Preload seq=0xFFFE, push 3 records -> out_seq reads 0xFFFE, 0xFFFF, 0x0000 in order.
//  6 rst asserted with count=9 mid-drain -> next cycle count=0, out_valid=0, overflow=0.

Source files
------------

// File: rtl/retire_trace_if.sv
// Retirement-trace bus between the MIPS datapath observer, the trace FIFO and its host consumer.
// The master side produces retire records and drains the FIFO; the slave side is the FIFO itself.
interface retire_trace_if #(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic [31:0]       in_pc;
    logic [31:0]       in_instr;
    logic              in_reg_write;
    logic [4:0]        in_write_reg;
    logic [31:0]       in_write_data;
    logic              in_mem_write;

    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_seq;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic              out_wr_en;
    logic [4:0]        out_wr_reg;
    logic [31:0]       out_wr_data;

    logic [ADDR_W:0]   count;
    logic              stall_req;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              clr_overflow;

    modport master (
        output in_valid, in_pc, in_instr, in_reg_write, in_write_reg, in_write_data, in_mem_write,
        output out_ready, clr_overflow,
        input  out_valid, out_seq, out_pc, out_instr, out_wr_en, out_wr_reg, out_wr_data,
        input  count, stall_req, overflow, drop_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_reg_write, in_write_reg, in_write_data, in_mem_write,
        input  out_ready, clr_overflow,
        output out_valid, out_seq, out_pc, out_instr, out_wr_en, out_wr_reg, out_wr_data,
        output count, stall_req, overflow, drop_cnt
    );
endinterface

// File: rtl/retire_trace_fifo.sv
// First-word-fall-through FIFO of retirement records from the single-cycle MIPS datapath,
// with sequence numbering, drop accounting and an early stall request for the PC.
module retire_trace_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int STALL_MARGIN = 2,
    parameter bit CAPTURE_ALL  = 1'b0
) (
    input logic           clk,
    input logic           rst,
    retire_trace_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_MARGIN);

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic [31:0] wr_data;
    } rec_t;

    rec_t              mem_q [DEPTH];
    rec_t              rec_in;
    rec_t              head;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] head_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              stall_q, stall_d;
    logic              want, pop, push, drop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        want = bus.in_valid && (CAPTURE_ALL
                                || (bus.in_reg_write && (bus.in_write_reg != 5'd0))
                                || bus.in_mem_write);
        pop  = (count_q != '0) && bus.out_ready;
        push = want && ((count_q != FULL_CNT) || pop);
        drop = want && !push;

        rec_in.seq     = seq_q;
        rec_in.pc      = bus.in_pc;
        rec_in.instr   = bus.in_instr;
        rec_in.wr_en   = bus.in_reg_write && (bus.in_write_reg != 5'd0);
        rec_in.wr_reg  = bus.in_write_reg;
        rec_in.wr_data = bus.in_write_data;

        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        seq_d   = want ? seq_q + 16'd1 : seq_q;
        stall_d = (count_d >= STALL_CNT);

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // NOTE: record storage is not reset; out_valid (count != 0) decides whether it means anything.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rec_in;
    end

    // While empty, show the slot just popped so out_* keep their last value.
    assign head_idx = (count_q != '0) ? rd_ptr_q : rd_ptr_q - ADDR_W'(1);
    assign head     = mem_q[head_idx];

    assign bus.out_valid   = (count_q != '0);
    assign bus.out_seq     = head.seq;
    assign bus.out_pc      = head.pc;
    assign bus.out_instr   = head.instr;
    assign bus.out_wr_en   = head.wr_en;
    assign bus.out_wr_reg  = head.wr_reg;
    assign bus.out_wr_data = head.wr_data;
    assign bus.count       = count_q;
    assign bus.stall_req   = stall_q;
    assign bus.overflow    = overflow_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Randomized bench for retire_trace_fifo against a queue-based record model.
// Each scenario task drives its own stimulus and compares DUT outputs against the model inline.
module tb_retire_trace_fifo;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic [31:0] wr_data;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    retire_trace_if #(.ADDR_W(4)) bus ();
    retire_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .STALL_MARGIN(MARGIN), .CAPTURE_ALL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rec_t        mq[$];
    logic [15:0] m_seq   = 16'd0;
    logic [31:0] m_pc    = 32'd0;
    bit          m_ovf   = 1'b0;
    bit          m_stall = 1'b0;
    int          m_drop  = 0;
    int          n_total = 0;
    int          n_pass  = 0;

    function automatic logic [117:0] pack_rec(rec_t r);
        return {r.seq, r.pc, r.instr, r.wr_en, r.wr_reg, r.wr_data};
    endfunction

    function automatic logic [117:0] dut_head();
        return {bus.out_seq, bus.out_pc, bus.out_instr, bus.out_wr_en, bus.out_wr_reg, bus.out_wr_data};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
    task automatic tick(input bit v, input bit rw, input logic [4:0] rd, input bit mw,
                        input bit rdy, input bit clr);
        bit   want, pop, push;
        rec_t r;
        bus.in_valid      = v;
        bus.in_pc         = m_pc;
        bus.in_instr      = $urandom;
        bus.in_reg_write  = rw;
        bus.in_write_reg  = rd;
        bus.in_write_data = $urandom;
        bus.in_mem_write  = mw;
        bus.out_ready     = rdy;
        bus.clr_overflow  = clr;
        r.seq = m_seq; r.pc = m_pc; r.instr = bus.in_instr;
        r.wr_en = rw && (rd != 5'd0); r.wr_reg = rd; r.wr_data = bus.in_write_data;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_seq = 16'd0; m_pc = 32'd0; m_ovf = 1'b0; m_drop = 0; m_stall = 1'b0;
        end else begin
            want = v && ((rw && (rd != 5'd0)) || mw);
            pop  = (mq.size() > 0) && rdy;
            push = want && ((mq.size() < DEPTH) || pop);
            if (pop)  mq.delete(0);
            if (push) mq.push_back(r);
            if (want) m_seq = m_seq + 16'd1;
            if (clr) begin
                m_ovf = 1'b0; m_drop = 0;
            end else if (want && !push) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            m_stall = (mq.size() >= DEPTH - MARGIN);
            if (v) m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(0, 0, 5'd0, 0, 0, 0);
        tick(0, 0, 5'd0, 0, 0, 0);
        rst = 1'b0;
        n_total++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.stall_req !== 1'b0) $display("FAIL reset_stall: got %b exp 0", bus.stall_req); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", bus.overflow); else n_pass++;
        n_total++; if (bus.drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d exp 0", bus.drop_cnt); else n_pass++;
    endtask

    task automatic test_basic_capture();
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 5'd8, 0, 0, 0);
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid%0d: got %b exp 1", i, bus.out_valid); else n_pass++;
        end
        n_total++; if (bus.count !== 5'd3) $display("FAIL basic_count: got %0d exp 3", bus.count); else n_pass++;
        n_total++; if (bus.out_seq !== 16'd0) $display("FAIL basic_seq: got %0h exp 0", bus.out_seq); else n_pass++;
        n_total++; if (bus.out_pc !== 32'd0) $display("FAIL basic_pc: got %0h exp 0", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_wr_reg !== 5'd8) $display("FAIL basic_wr_reg: got %0d exp 8", bus.out_wr_reg); else n_pass++;
        n_total++; if (dut_head() !== pack_rec(mq[0])) $display("FAIL basic_head: got %0h exp %0h", dut_head(), pack_rec(mq[0])); else n_pass++;
    endtask

    task automatic test_filter();
        tick(1, 1, 5'd0, 0, 0, 0);
        n_total++; if (bus.count !== 5'd3) $display("FAIL filter_rd0: got %0d exp 3", bus.count); else n_pass++;
        tick(1, 0, 5'd3, 0, 0, 0);
        n_total++; if (bus.count !== 5'd3) $display("FAIL filter_beq: got %0d exp 3", bus.count); else n_pass++;
        tick(1, 0, 5'd5, 1, 0, 0);
        n_total++; if (bus.count !== 5'd4) $display("FAIL filter_sw: got %0d exp 4", bus.count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++; if (bus.out_seq !== 16'(k)) $display("FAIL filter_seq%0d: got %0d exp %0d", k, bus.out_seq, k); else n_pass++;
            if (k == 3) begin
                n_total++; if (bus.out_wr_en !== 1'b0) $display("FAIL filter_sw_wren: got %b exp 0", bus.out_wr_en); else n_pass++;
            end
            tick(0, 0, 5'd0, 0, 1, 0);
        end
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL filter_empty: got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        logic [15:0] exp_seq;
        test_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1, 1, 5'($urandom_range(31, 1)), 0, 0, 0);
            n_total++; if (bus.count !== 5'(i)) $display("FAIL fill_count%0d: got %0d exp %0d", i, bus.count, i); else n_pass++;
            n_total++; if (bus.stall_req !== (i >= DEPTH - MARGIN)) $display("FAIL fill_stall%0d: got %b exp %b", i, bus.stall_req, i >= DEPTH - MARGIN); else n_pass++;
        end
        tick(1, 1, 5'd4, 0, 0, 0);
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", bus.overflow); else n_pass++;
        n_total++; if (bus.drop_cnt !== 8'd1) $display("FAIL ovf_drop: got %0d exp 1", bus.drop_cnt); else n_pass++;
        n_total++; if (bus.count !== 5'd16) $display("FAIL ovf_count: got %0d exp 16", bus.count); else n_pass++;
        // Clear wins over a drop in the same cycle; that drop still consumes a sequence number.
        tick(1, 1, 5'd4, 0, 0, 1);
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL clr_prio_flag: got %b exp 0", bus.overflow); else n_pass++;
        n_total++; if (bus.drop_cnt !== 8'd0) $display("FAIL clr_prio_drop: got %0d exp 0", bus.drop_cnt); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_total++; if (dut_head() !== pack_rec(mq[0])) $display("FAIL stream_head%0d: got %0h exp %0h", c, dut_head(), pack_rec(mq[0])); else n_pass++;
            tick(1, 1, 5'd7, 0, 1, 0);
            n_total++; if (bus.count !== 5'd16) $display("FAIL stream_count%0d: got %0d exp 16", c, bus.count); else n_pass++;
            n_total++; if (bus.drop_cnt !== 8'd0) $display("FAIL stream_drop%0d: got %0d exp 0", c, bus.drop_cnt); else n_pass++;
        end
        // Seqs 0..15 accepted, 16 and 17 dropped, then 18..22 streamed in.
        for (int k = 0; k < DEPTH; k++) begin
            exp_seq = 16'(k + 5);
            if (k + 5 >= DEPTH) exp_seq = 16'(k + 7);
            n_total++; if (bus.out_seq !== exp_seq) $display("FAIL gap_seq%0d: got %0d exp %0d", k, bus.out_seq, exp_seq); else n_pass++;
            n_total++; if (dut_head() !== pack_rec(mq[0])) $display("FAIL gap_head%0d: got %0h exp %0h", k, dut_head(), pack_rec(mq[0])); else n_pass++;
            tick(0, 0, 5'd0, 0, 1, 0);
        end
        n_total++; if (bus.count !== 5'd0) $display("FAIL drain_count: got %0d exp 0", bus.count); else n_pass++;
        n_total++; if (bus.stall_req !== 1'b0) $display("FAIL drain_stall: got %b exp 0", bus.stall_req); else n_pass++;
    endtask

    task automatic test_random();
        bit rdy;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            rdy = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            tick($urandom_range(3) != 0, 1'($urandom), 5'($urandom), $urandom_range(7) == 0,
                 rdy, $urandom_range(49) == 0);
            n_total++; if (bus.count !== 5'(mq.size())) $display("FAIL rand_count%0d: got %0d exp %0d", i, bus.count, mq.size()); else n_pass++;
            n_total++; if (bus.out_valid !== (mq.size() > 0)) $display("FAIL rand_valid%0d: got %b exp %b", i, bus.out_valid, mq.size() > 0); else n_pass++;
            n_total++; if (bus.stall_req !== m_stall) $display("FAIL rand_stall%0d: got %b exp %b", i, bus.stall_req, m_stall); else n_pass++;
            n_total++; if (bus.overflow !== m_ovf) $display("FAIL rand_ovf%0d: got %b exp %b", i, bus.overflow, m_ovf); else n_pass++;
            n_total++; if (bus.drop_cnt !== 8'(m_drop)) $display("FAIL rand_drop%0d: got %0d exp %0d", i, bus.drop_cnt, m_drop); else n_pass++;
            if (mq.size() > 0) begin
                n_total++; if (dut_head() !== pack_rec(mq[0])) $display("FAIL rand_head%0d: got %0h exp %0h", i, dut_head(), pack_rec(mq[0])); else n_pass++;
            end
        end
    endtask

    task automatic test_seq_wrap();
        test_reset();
        for (int i = 0; i < 65534; i++) tick(1, 1, 5'd1, 0, 1, 0);
        tick(0, 0, 5'd0, 0, 1, 0);
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL wrap_empty: got %b exp 0", bus.out_valid); else n_pass++;
        for (int i = 0; i < 3; i++) tick(1, 1, 5'd2, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_total++; if (bus.out_seq !== 16'hFFFE + 16'(k)) $display("FAIL wrap_seq%0d: got %0h exp %0h", k, bus.out_seq, 16'hFFFE + 16'(k)); else n_pass++;
            tick(0, 0, 5'd0, 0, 1, 0);
        end
    endtask

    task automatic test_reset_mid_drain();
        test_reset();
        for (int i = 0; i <= DEPTH; i++) tick(1, 1, 5'd9, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 5'd0, 0, 1, 0);
        n_total++; if (bus.count !== 5'd9) $display("FAIL mid_count: got %0d exp 9", bus.count); else n_pass++;
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL mid_ovf: got %b exp 1", bus.overflow); else n_pass++;
        rst = 1'b1;
        tick(0, 0, 5'd0, 0, 1, 0);
        rst = 1'b0;
        n_total++; if (bus.count !== 5'd0) $display("FAIL rst_mid_count: got %0d exp 0", bus.count); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL rst_mid_ovf: got %b exp 0", bus.overflow); else n_pass++;
        n_total++; if (bus.drop_cnt !== 8'd0) $display("FAIL rst_mid_drop: got %0d exp 0", bus.drop_cnt); else n_pass++;
        tick(1, 1, 5'd6, 0, 0, 0);
        n_total++; if (bus.out_seq !== 16'd0) $display("FAIL rst_mid_seq: got %0d exp 0", bus.out_seq); else n_pass++;
        n_total++; if (bus.out_pc !== 32'd0) $display("FAIL rst_mid_pc: got %0h exp 0", bus.out_pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_filter();
        test_fill_overflow();
        test_random();
        test_seq_wrap();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
